// File: rtl/uart_mem_bridge.sv
// UART command to memory bridge: runs single/burst accesses through the arbiter
// and queues read words and error codes in a response FIFO for the transmitter.
module uart_mem_bridge #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 15,
    parameter int LEN_W     = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [1:0]        cmd_error,
    output logic              mem_enable,
    output logic              mem_readWrite,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataIn,
    input  logic [DATA_W-1:0] mem_dataOut,
    input  logic              arbitratorDone,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_mode,
    output logic [DATA_W-1:0] tx_word,
    output logic [7:0]        tx_byte,
    output logic              busy,
    output logic [7:0]        err_count
);
    localparam int PTR_W = $clog2(RSP_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ACCESS, S_GAP, S_ERR} state_t;
    state_t state_q, state_d;

    logic [7:0]        op_q;
    logic [1:0]        cmd_err_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [7:0]        code_q, code_d;
    logic              en_d;
    logic              push, pop, push_mode;
    logic [DATA_W-1:0] push_data;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              fifo_full, fifo_empty, is_read;
    logic [ADDR_W:0]   end_addr;
    logic              fifo_mode [RSP_DEPTH];
    logic [DATA_W-1:0] fifo_data [RSP_DEPTH];

    assign fifo_full  = (count == (PTR_W+1)'(RSP_DEPTH));
    assign fifo_empty = (count == '0);
    assign is_read    = !mem_readWrite;
    // Last beat address with a carry bit; a set carry means the burst runs off the top.
    assign end_addr   = {1'b0, mem_address} + (ADDR_W+1)'(remaining_q);

    assign cmd_ready = (state_q == S_IDLE);
    assign tx_valid  = !fifo_empty;
    assign tx_mode   = tx_valid && fifo_mode[rd_ptr];
    assign tx_word   = tx_mode ? fifo_data[rd_ptr] : '0;
    assign tx_byte   = (tx_valid && !fifo_mode[rd_ptr]) ? fifo_data[rd_ptr][7:0] : 8'h00;
    assign pop       = tx_valid && tx_ready;

    // Only this FSM pushes, so a FIFO that is not full now cannot fill before the
    // read completes; gating mem_enable on the current full flag is sufficient.
    always_comb begin
        state_d   = state_q;
        en_d      = 1'b0;
        code_d    = code_q;
        push      = 1'b0;
        push_mode = 1'b0;
        push_data = '0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (cmd_err_q != 2'd0) begin
                    state_d = S_ERR;
                    code_d  = {6'd0, cmd_err_q};
                end else if (op_q != 8'h00 && op_q != 8'h01) begin
                    state_d = S_ERR;
                    code_d  = 8'h04;
                end else if (end_addr[ADDR_W]) begin
                    state_d = S_ERR;
                    code_d  = 8'h05;
                end else begin
                    state_d = S_ACCESS;
                    en_d    = !(is_read && fifo_full);
                end
            end
            S_ACCESS: begin
                if (mem_enable) begin
                    if (arbitratorDone) begin
                        push      = is_read;
                        push_mode = 1'b1;
                        push_data = mem_dataOut;
                        state_d   = (remaining_q == '0) ? S_IDLE : S_GAP;
                    end else begin
                        en_d = 1'b1;
                    end
                end else begin
                    en_d = !(is_read && fifo_full);
                end
            end
            S_GAP: begin
                state_d = S_ACCESS;
                en_d    = !(is_read && fifo_full);
            end
            S_ERR: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    push_data = {{(DATA_W-8){1'b0}}, code_q};
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            mem_enable    <= 1'b0;
            busy          <= 1'b0;
            err_count     <= 8'h00;
            code_q        <= 8'h00;
            op_q          <= 8'h00;
            cmd_err_q     <= 2'd0;
            remaining_q   <= '0;
            mem_readWrite <= 1'b0;
            mem_address   <= '0;
            mem_dataIn    <= '0;
        end else begin
            state_q    <= state_d;
            mem_enable <= en_d;
            busy       <= (state_d != S_IDLE);
            code_q     <= code_d;
            if (state_q == S_IDLE && cmd_valid) begin
                op_q          <= cmd_op;
                cmd_err_q     <= cmd_error;
                remaining_q   <= cmd_len;
                mem_readWrite <= (cmd_op == 8'h00);
                mem_address   <= cmd_addr;
                mem_dataIn    <= cmd_data;
            end
            if (state_q == S_GAP) begin
                mem_address <= mem_address + ADDR_W'(1);
                remaining_q <= remaining_q - LEN_W'(1);
            end
            if (state_q == S_ERR && !fifo_full && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mode[wr_ptr] <= push_mode;
            fifo_data[wr_ptr] <= push_data;
        end
    end
endmodule
